// File: rtl/qspi_tgt_pkg.sv
// qspi_tgt_pkg: shared constants and types for the QSPI memory responder.
//   CMD_*      : command bytes recognised on the bus
//   state_t    : responder FSM states
//   CNT_W      : width of the nibble counters (address and dummy phases)
package qspi_tgt_pkg;

    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;
    localparam logic [7:0] CMD_WREN   = 8'h06;

    // Wide enough for up to 15 dummy nibbles and up to 16 address nibbles.
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

endpackage

// File: rtl/qspi_tgt_mem.sv
// qspi_tgt_mem: DEPTH x 8 backing store, combinational read, clocked write.
//   i_clk   : clock
//   i_we    : write enable (writes i_wdata to i_addr on rising i_clk)
//   i_addr  : shared read/write address
//   i_wdata : write byte
//   o_rdata : byte at i_addr (combinational)
// Contents are deliberately not reset.
module qspi_tgt_mem #(
    parameter int DEPTH = 256,
    parameter int MAW   = $clog2(DEPTH)
) (
    input  logic           i_clk,
    input  logic           i_we,
    input  logic [MAW-1:0] i_addr,
    input  logic [7:0]     i_wdata,
    output logic [7:0]     o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/qspi_target.sv
// qspi_target: device end of the quad-SPI bus, serving quad reads (0xEB)
// and quad writes (0x38) from an internal byte array. Bus SCK is clk.
//   clk       : system clock / bus clock, all sampling on rising edge
//   reset     : asynchronous active-low reset
//   cs_n      : chip select, active low; high at any edge forces IDLE
//   dq_in     : nibble from master
//   dq_out    : read nibble to master (registered)
//   dq_oe     : per-lane output enable, 4'hF while driving
//   active    : transaction in progress (state != IDLE)
//   proto_err : one-cycle pulse on unknown command or partial write byte
//   state_dbg : current FSM state encoding, for observation
// Optional macro QSPI_TGT_WEL_EN adds a write-enable latch set by 0x06.
module qspi_target
    import qspi_tgt_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int DUMMY = 4,
    parameter int AW    = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic [3:0] dq_in,
    output logic [3:0] dq_out,
    output logic [3:0] dq_oe,
    output logic       active,
    output logic       proto_err,
    output logic [2:0] state_dbg
);

    localparam int MAW       = $clog2(DEPTH);
    localparam int ADDR_NIBS = AW / 4;
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_NIBS - 1);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY - 1);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cmd_hi;
    logic [CNT_W-1:0] r_cnt;
    logic [MAW-1:0]   r_addr;
    logic             r_is_wr;
    logic             r_have_hi;
    logic [3:0]       r_wd_hi;
    logic             r_lo_out;   // dq_out currently carries a low nibble
    logic [3:0]       r_dq_out;
    logic [3:0]       r_dq_oe;
    logic             r_proto_err;
    logic [7:0]       w_cmd;
    logic             w_cmd_err;
    logic             w_part_err;
    logic             w_we;
    logic [MAW-1:0]   w_mem_addr;
    logic [7:0]       w_rdata;
`ifdef QSPI_TGT_WEL_EN
    logic             r_wel;
    logic             r_wren_pend;
`endif

    assign w_cmd      = {r_cmd_hi, dq_in};
    assign w_we       = !cs_n && (r_state == ST_WDATA) && r_have_hi;
    assign w_part_err = cs_n && (r_state == ST_WDATA) && r_have_hi;
    // While a low nibble is on the bus, look ahead to the next byte so its
    // high nibble can be registered on the following edge.
    assign w_mem_addr = ((r_state == ST_RDATA) && r_lo_out) ? r_addr + MAW'(1) : r_addr;

    qspi_tgt_mem #(.DEPTH(DEPTH), .MAW(MAW)) u_mem (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_addr  (w_mem_addr),
        .i_wdata ({r_wd_hi, dq_in}),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_next    = r_state;
        w_cmd_err = 1'b0;
        case (r_state)
            ST_IDLE: w_next = ST_CMD;
            ST_CMD: begin
                if (w_cmd == CMD_QREAD) begin
                    w_next = ST_ADDR;
                end else if (w_cmd == CMD_QWRITE) begin
`ifdef QSPI_TGT_WEL_EN
                    if (r_wel) begin
                        w_next = ST_ADDR;
                    end else begin
                        w_next    = ST_IGNORE;
                        w_cmd_err = 1'b1;
                    end
`else
                    w_next = ST_ADDR;
`endif
`ifdef QSPI_TGT_WEL_EN
                end else if (w_cmd == CMD_WREN) begin
                    w_next = ST_IGNORE;
`endif
                end else begin
                    w_next    = ST_IGNORE;
                    w_cmd_err = 1'b1;
                end
            end
            ST_ADDR: begin
                if (r_cnt == ADDR_LAST) begin
                    w_next = r_is_wr ? ST_WDATA : ST_DUMMY;
                end
            end
            ST_DUMMY: begin
                if (r_cnt == DUMMY_LAST) begin
                    w_next = ST_RDATA;
                end
            end
            default: w_next = r_state;
        endcase
        if (cs_n) begin
            w_next    = ST_IDLE;
            w_cmd_err = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_hi    <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_is_wr     <= 1'b0;
            r_have_hi   <= 1'b0;
            r_wd_hi     <= '0;
            r_lo_out    <= 1'b0;
            r_dq_out    <= '0;
            r_dq_oe     <= '0;
            r_proto_err <= 1'b0;
`ifdef QSPI_TGT_WEL_EN
            r_wel       <= 1'b0;
            r_wren_pend <= 1'b0;
`endif
        end else if (cs_n) begin
            r_dq_out    <= '0;
            r_dq_oe     <= '0;
            r_have_hi   <= 1'b0;
            r_lo_out    <= 1'b0;
            r_is_wr     <= 1'b0;
            r_proto_err <= w_part_err;
`ifdef QSPI_TGT_WEL_EN
            // WREN takes effect only if nothing followed the command byte.
            if (r_wren_pend && (r_state == ST_IGNORE)) begin
                r_wel <= 1'b1;
            end else if (r_is_wr) begin
                r_wel <= 1'b0;
            end
            r_wren_pend <= 1'b0;
`endif
        end else begin
            r_proto_err <= w_cmd_err;
            case (r_state)
                ST_IDLE: begin
                    r_cmd_hi <= dq_in;
                    r_cnt    <= '0;
                end
                ST_CMD: begin
                    r_is_wr <= (w_cmd == CMD_QWRITE);
                    r_cnt   <= '0;
`ifdef QSPI_TGT_WEL_EN
                    r_wren_pend <= (w_cmd == CMD_WREN);
`endif
                end
                ST_ADDR: begin
                    r_addr <= (r_addr << 4) | MAW'(dq_in);
                    r_cnt  <= (r_cnt == ADDR_LAST) ? '0 : r_cnt + 1'b1;
                end
                ST_DUMMY: begin
                    if (r_cnt == DUMMY_LAST) begin
                        r_dq_out <= w_rdata[7:4];
                        r_dq_oe  <= 4'hF;
                        r_lo_out <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (!r_lo_out) begin
                        r_dq_out <= w_rdata[3:0];
                        r_lo_out <= 1'b1;
                    end else begin
                        r_dq_out <= w_rdata[7:4];
                        r_addr   <= r_addr + MAW'(1);
                        r_lo_out <= 1'b0;
                    end
                end
                ST_WDATA: begin
                    if (!r_have_hi) begin
                        r_wd_hi   <= dq_in;
                        r_have_hi <= 1'b1;
                    end else begin
                        r_have_hi <= 1'b0;
                        r_addr    <= r_addr + MAW'(1);
                    end
                end
                ST_IGNORE: begin
                    r_dq_oe <= '0;
`ifdef QSPI_TGT_WEL_EN
                    r_wren_pend <= 1'b0;
`endif
                end
                default: r_dq_oe <= '0;
            endcase
        end
    end

    assign dq_out    = r_dq_out;
    assign dq_oe     = r_dq_oe;
    assign proto_err = r_proto_err;
    assign active    = (r_state != ST_IDLE);
    assign state_dbg = r_state;

endmodule

// File: tb/tb_qspi_target.sv
// tb_qspi_target: self-checking bench for qspi_target (DEPTH=256, DUMMY=4).
// Inputs are driven between edges; outputs are sampled 1 time unit after
// each rising clk. A byte-level model of memory feeds an expected-nibble
// queue for every read; nibbles are popped and compared as they appear.
module tb_qspi_target;
    import qspi_tgt_pkg::*;

    localparam int TB_DUMMY = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cs_n = 1'b1;
    logic [3:0] dq_in = 4'h0;
    logic [3:0] dq_out;
    logic [3:0] dq_oe;
    logic       active;
    logic       proto_err;
    logic [2:0] state_dbg;

    int total = 0;
    int bad = 0;

    logic [7:0] model [256];
    logic [7:0] wbuf [$];
    logic [3:0] exp_q [$];

    qspi_target #(.DEPTH(256), .DUMMY(TB_DUMMY), .AW(24)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .dq_in     (dq_in),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .active    (active),
        .proto_err (proto_err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic send_nib(input logic [3:0] n);
        cs_n = 1'b0;
        dq_in = n;
        @(posedge clk);
        #1;
    endtask

    task automatic deselect();
        cs_n = 1'b1;
        dq_in = 4'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        send_nib(cmd[7:4]);
        send_nib(cmd[3:0]);
        for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
    endtask

    task automatic send_wren();
`ifdef QSPI_TGT_WEL_EN
        send_nib(CMD_WREN[7:4]);
        send_nib(CMD_WREN[3:0]);
        deselect();
`endif
    endtask

    // Writes every byte of wbuf starting at a, and updates the model.
    task automatic do_write(input logic [23:0] a);
        logic [7:0] idx;
        send_wren();
        send_hdr(CMD_QWRITE, a);
        for (int i = 0; i < wbuf.size(); i++) begin
            send_nib(wbuf[i][7:4]);
            send_nib(wbuf[i][3:0]);
            idx = a[7:0] + 8'(i);
            model[idx] = wbuf[i];
            total++;
            if (proto_err !== 1'b0) begin
                bad++;
                $display("FAIL write_perr: got %b want 0 (byte %0d)", proto_err, i);
            end
        end
        deselect();
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("FAIL write_end_perr: got %b want 0", proto_err);
        end
        wbuf.delete();
    endtask

    // Reads nbytes from a and checks every nibble against the model.
    task automatic do_read(input logic [23:0] a, input int nbytes);
        logic [7:0] idx;
        logic [3:0] e;
        for (int i = 0; i < nbytes; i++) begin
            idx = a[7:0] + 8'(i);
            exp_q.push_back(model[idx][7:4]);
            exp_q.push_back(model[idx][3:0]);
        end
        send_hdr(CMD_QREAD, a);
        for (int d = 0; d < TB_DUMMY; d++) begin
            send_nib(4'($urandom_range(0, 15)));
            total++;
            if (d < TB_DUMMY - 1 && dq_oe !== 4'h0) begin
                bad++;
                $display("FAIL dummy_oe: got %h want 0 (dummy %0d)", dq_oe, d);
            end else if (d == TB_DUMMY - 1 && dq_oe !== 4'hF) begin
                bad++;
                $display("FAIL first_oe: got %h want f", dq_oe);
            end
        end
        for (int k = 0; k < 2 * nbytes; k++) begin
            if (k > 0) send_nib(4'($urandom_range(0, 15)));
            e = exp_q.pop_front();
            total++;
            if (dq_out !== e || dq_oe !== 4'hF || proto_err !== 1'b0) begin
                bad++;
                $display("FAIL rdata: addr %h nib %0d got %h/oe %h/perr %b want %h/oe f/perr 0",
                         a, k, dq_out, dq_oe, proto_err, e);
            end
        end
        deselect();
        total++;
        if (dq_oe !== 4'h0 || active !== 1'b0) begin
            bad++;
            $display("FAIL read_end: got oe %h active %b want 0 0", dq_oe, active);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dq_out !== 4'h0 || dq_oe !== 4'h0 || active !== 1'b0 ||
            proto_err !== 1'b0 || state_dbg !== 3'd0) begin
            bad++;
            $display("FAIL reset: got out %h oe %h act %b perr %b st %0d want all 0",
                     dq_out, dq_oe, active, proto_err, state_dbg);
        end
        reset = 1'b1;
        deselect();
        // Give every location a known value.
        for (int i = 0; i < 256; i++) wbuf.push_back(8'($urandom_range(0, 255)));
        do_write(24'h000000);
    endtask

    task automatic test_write_read();
        wbuf.push_back(8'hA5);
        wbuf.push_back(8'h3C);
        do_write(24'h000010);
        do_read(24'h000010, 2);
        // Upper address bits beyond DEPTH are ignored.
        do_read(24'h5A5A10, 2);
    endtask

    task automatic test_wrap();
        wbuf.push_back(8'h11);
        wbuf.push_back(8'h22);
        do_write(24'h0000FF);
        do_read(24'h0000FF, 2);
        do_read(24'h000000, 1);
    endtask

    task automatic test_abort();
        send_nib(4'hE);
        send_nib(4'hB);
        send_nib(4'h0);
        send_nib(4'h0);
        send_nib(4'h0);
        total++;
        if (active !== 1'b1) begin
            bad++;
            $display("FAIL abort_active_mid: got %b want 1", active);
        end
        deselect();
        total++;
        if (dq_oe !== 4'h0 || active !== 1'b0) begin
            bad++;
            $display("FAIL abort: got oe %h active %b want 0 0", dq_oe, active);
        end
        do_read(24'h000010, 2);
    endtask

    task automatic test_unknown();
        send_nib(4'h9);
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("FAIL unk_perr_c0: got %b want 0", proto_err);
        end
        send_nib(4'hF);
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL unk_perr_c1: got %b want 1", proto_err);
        end
        for (int c = 2; c < 21; c++) begin
            send_nib(4'($urandom_range(0, 15)));
            total++;
            if (proto_err !== 1'b0 || dq_oe !== 4'h0) begin
                bad++;
                $display("FAIL unk_quiet: cycle %0d got perr %b oe %h want 0 0",
                         c, proto_err, dq_oe);
            end
        end
        deselect();
        do_read(24'h000010, 2);
        do_read(24'h0000FF, 2);
    endtask

    task automatic test_partial();
        wbuf.push_back(8'h00);
        wbuf.push_back(8'h5A);
        do_write(24'h000020);
        send_wren();
        send_hdr(CMD_QWRITE, 24'h000020);
        send_nib(4'h7);
        send_nib(4'hE);
        send_nib(4'h5);
        model[8'h20] = 8'h7E;
        deselect();
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL partial_perr: got %b want 1", proto_err);
        end
        send_nib(4'hE);
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("FAIL partial_perr_len: got %b want 0", proto_err);
        end
        deselect();
        do_read(24'h000020, 2);
    endtask

    task automatic test_back_to_back();
        logic [23:0] a;
        for (int r = 0; r < 3; r++) begin
            a = 24'($urandom_range(0, 255));
            for (int i = 0; i < 4; i++) wbuf.push_back(8'($urandom_range(0, 255)));
            do_write(a);
            do_read(a, 5);
        end
    endtask

`ifdef QSPI_TGT_WEL_EN
    // Write without a preceding WREN must be refused.
    task automatic test_wel();
        for (int pass = 0; pass < 2; pass++) begin
            send_hdr(CMD_QWRITE, 24'h000030);
            send_nib(4'h4);
            send_nib(4'h4);
            deselect();
            do_read(24'h000030, 1);
            if (pass == 0) begin
                wbuf.push_back(8'h99);
                do_write(24'h000030);
                do_read(24'h000030, 1);
            end
        end
        send_nib(CMD_QWRITE[7:4]);
        send_nib(CMD_QWRITE[3:0]);
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL wel_perr: got %b want 1", proto_err);
        end
        deselect();
    endtask
`else
    task automatic test_wren_unknown();
        send_nib(4'h0);
        send_nib(4'h6);
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL wren_unknown: got %b want 1", proto_err);
        end
        deselect();
    endtask
`endif

    task automatic test_reset_mid();
        send_hdr(CMD_QREAD, 24'h000040);
        for (int d = 0; d < TB_DUMMY + 1; d++) send_nib(4'h0);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (dq_out !== 4'h0 || dq_oe !== 4'h0 || active !== 1'b0 || proto_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_rd: got out %h oe %h act %b perr %b want 0",
                     dq_out, dq_oe, active, proto_err);
        end
        cs_n = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        deselect();
        // High nibble latched, low nibble never seen: byte must not land.
        send_wren();
        send_hdr(CMD_QWRITE, 24'h000041);
        send_nib(4'hF);
        #2;
        reset = 1'b0;
        #1;
        cs_n = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        deselect();
        do_read(24'h000040, 2);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_abort();
        test_unknown();
        test_partial();
        test_back_to_back();
`ifdef QSPI_TGT_WEL_EN
        test_wel();
`else
        test_wren_unknown();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
